// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Sequencing controller for the multicycle ARM-subset core.
//            Steps the shared datapath through FETCH/DECODE/EXECUTE/MEM/WB,
//            holds the NZCV flag register and evaluates the condition field.
// Options  : BX_SUPPORT_EN - when defined, adds the BX state (Rm -> PC).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic [15:0] Inst19to4,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        LinkWrite,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXECR  = STATE_W'(6),
    S_EXECI  = STATE_W'(7),
    S_ALUWB  = STATE_W'(8),
    S_BRANCH = STATE_W'(9)
`ifdef BX_SUPPORT_EN
    , S_BX   = STATE_W'(10)
`endif
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  state_t     state;
  state_t     next_state;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       alu_supported;
  logic       alu_arith;
  logic [3:0] alu_op;

  assign alu_op = Funct[4:1];

`ifdef BX_SUPPORT_EN
  logic is_bx;
  assign is_bx = (Op == 2'b00) && ({Funct, Inst19to4} == {6'b010010, 16'hFFF1});
`else
  logic unused_inst;
  assign unused_inst = ^Inst19to4;
`endif

  // Condition field evaluated against the committed (registered) flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Classify the DP opcode: which ALU ops exist, and which produce C/V
  always_comb begin
    alu_supported = 1'b0;
    alu_arith     = 1'b0;
    case (alu_op)
      ALU_AND, ALU_ORR, ALU_MOV: alu_supported = 1'b1;
      ALU_SUB, ALU_ADD, ALU_CMP: begin
        alu_supported = 1'b1;
        alu_arith     = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state selection
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (cond_ex) begin
          case (Op)
            2'b01: if (!Funct[5]) next_state = S_MEMADR;
            2'b10: next_state = S_BRANCH;
            2'b00: if (alu_supported) next_state = Funct[5] ? S_EXECI : S_EXECR;
            default: ;
          endcase
`ifdef BX_SUPPORT_EN
          if (is_bx) next_state = S_BX;
`endif
        end
      end
      S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXECR, S_EXECI: next_state = (alu_op == ALU_CMP) ? S_FETCH : S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // State and flag register; flags commit on the edge leaving an execute state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state <= next_state;
      if (state == S_EXECR || state == S_EXECI) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (alu_arith) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Moore decode of the control word; everything forced low while in reset
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    LinkWrite  = 1'b0;
    ResultSrc  = 2'b00;
    ALUControl = ALU_AND;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        ALUControl = ALU_ADD; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = ALU_ADD; ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUControl = ALU_ADD;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        // A load into R15 redirects the PC instead of touching the register file
        if (Rd == 4'd15) PCWrite = 1'b1;
        else             RegWrite = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; MemWrite = 1'b1; RegSrc = 2'b10;
      end
      S_EXECR: ALUControl = alu_op;
      S_EXECI: begin
        ALUSrcB = 2'b01; ALUControl = alu_op;
      end
      S_ALUWB: begin
        if (Rd == 4'd15) PCWrite = 1'b1;
        else             RegWrite = 1'b1;
      end
      S_BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = 2'b01; ImmSrc = 2'b10; ALUControl = ALU_ADD;
        ResultSrc = 2'b10; PCWrite = 1'b1; LinkWrite = Funct[4];
      end
`ifdef BX_SUPPORT_EN
      S_BX: begin
        ALUControl = ALU_MOV; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!RESET_N) begin
      PCWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      RegWrite = 1'b0; LinkWrite = 1'b0; ResultSrc = 2'b00; ALUControl = 4'b0000;
      ALUSrcA = 1'b0; ALUSrcB = 2'b00; ImmSrc = 2'b00; RegSrc = 2'b00;
    end
  end

  assign Flags = flags_q;

endmodule
`default_nettype wire
